// File: rtl/countdown_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// countdown_sequencer_pkg
//   Shared definitions for the countdown sequencer:
//     - state_t : 2-bit sequencer state encoding
//                 IDLE=2'b00, RUN=2'b01, FIN=2'b10. 2'b11 is illegal and
//                 recovers to IDLE on the next edge.
//     - CNT_WIDTH_DEFAULT : default counter width.
// -----------------------------------------------------------------------------
package countdown_sequencer_pkg;

  localparam int CNT_WIDTH_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

endpackage : countdown_sequencer_pkg

// File: rtl/down_counter_load.sv
// -----------------------------------------------------------------------------
// down_counter_load
//   Loadable down-counter built from toggle-plus-load cells. Each bit toggles
//   when a decrement is requested and every lower bit is 0 (borrow chain, the
//   mirror of an up-counter carry chain). Load overrides decrement.
//
// Ports:
//   clk    in   rising-edge clock
//   clr_n  in   asynchronous active-low clear (q -> 0)
//   load   in   load d into q on the next edge
//   d      in   load value [WIDTH-1:0]
//   dec    in   decrement request (ignored while load is high)
//   q      out  current count [WIDTH-1:0]
// -----------------------------------------------------------------------------
module down_counter_load
  import countdown_sequencer_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             dec,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  // w_borrow[i] is the toggle enable of bit i: a decrement reaches bit i only
  // when all bits below it are 0 and must borrow.
  logic [WIDTH-1:0] w_borrow;

  assign w_borrow[0] = dec;

  for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
    assign w_borrow[i] = w_borrow[i-1] & ~r_q[i-1];
  end

  // NOTE: clocked state is written with non-blocking assignments so every
  // flop samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else begin
      r_q <= r_q ^ w_borrow;  // T flip-flops: toggle where enabled
    end
  end

  assign q = r_q;

endmodule : down_counter_load

// File: rtl/countdown_sequencer.sv
// -----------------------------------------------------------------------------
// countdown_sequencer
//   Loads a cycle budget and counts it down to zero with a start/busy/done
//   handshake. start (priority over en, in every state) loads load_val; a
//   nonzero value enters RUN, zero goes straight to FIN. In RUN each enabled
//   cycle decrements; the 1->0 step enters FIN, which lasts exactly one cycle
//   and pulses done before returning to IDLE.
//
// Ports:
//   clk       in   rising-edge clock
//   clr_n     in   asynchronous active-low reset
//   start     in   load request, samples load_val
//   load_val  in   initial count [WIDTH-1:0]
//   en        in   count enable (used only in RUN)
//   count     out  current counter value [WIDTH-1:0]
//   busy      out  high while in RUN (decoded from state)
//   done      out  one-cycle pulse in FIN (decoded from state)
//   zero      out  combinational count == 0
// -----------------------------------------------------------------------------
module countdown_sequencer
  import countdown_sequencer_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_t r_state;
  state_t w_next_state;
  logic   w_dec;

  // RUN is only entered with a nonzero count and left on the 1->0 step, so
  // the counter never decrements from 0.
  assign w_dec = !start && (r_state == ST_RUN) && en;

  down_counter_load #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .clr_n (clr_n),
    .load  (start),
    .d     (load_val),
    .dec   (w_dec),
    .q     (count)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment first guarantees w_next_state is written on
  // every path, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    if (start) begin
      w_next_state = (load_val != '0) ? ST_RUN : ST_FIN;
    end else begin
      unique case (r_state)
        ST_IDLE: w_next_state = ST_IDLE;
        ST_RUN:  if (en && (count == WIDTH'(1))) w_next_state = ST_FIN;
        ST_FIN:  w_next_state = ST_IDLE;
        default: w_next_state = ST_IDLE;  // illegal 2'b11 recovers
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_FIN);
  assign zero = (count == '0);

endmodule : countdown_sequencer

// File: tb/tb_countdown_sequencer.sv
// -----------------------------------------------------------------------------
// tb_countdown_sequencer
//   Self-checking bench: directed scenarios followed by randomized stimulus,
//   all compared against a cycle-level behavioural model of the handshake.
// -----------------------------------------------------------------------------
module tb_countdown_sequencer;

  localparam int WIDTH = 6;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             clr_n;
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: remaining budget plus two flags.
  int m_count = 0;
  bit m_busy  = 1'b0;
  bit m_done  = 1'b0;

  countdown_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .load_val (load_val),
    .en       (en),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_busy  = 1'b0;
    m_done  = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the applied inputs.
  task automatic model_edge(input bit s, input int lv, input bit e);
    if (s) begin
      m_count = lv;
      m_busy  = (lv != 0);
      m_done  = (lv == 0);
    end else if (m_busy) begin
      m_done = 1'b0;
      if (e) begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, int'(count), m_count);
    check({tag, ".busy"},  int'(busy),  int'(m_busy));
    check({tag, ".done"},  int'(done),  int'(m_done));
    check({tag, ".zero"},  int'(zero),  int'(m_count == 0));
  endtask

  // Apply inputs away from the edge, clock once, update model, sample at +1.
  task automatic step(input string tag, input bit s, input int lv, input bit e);
    start    = s;
    load_val = WIDTH'(lv);
    en       = e;
    @(posedge clk);
    model_edge(s, lv, e);
    #1;
    check_all(tag);
  endtask

  initial begin
    int busy_cycles;
    int done_pulses;
    bit enp [6];

    clr_n    = 1'b0;
    start    = 1'b0;
    load_val = '0;
    en       = 1'b0;
    #2;
    model_reset();
    check_all("reset");
    #10 clr_n = 1'b1;  // released between edges

    // Basic run: 3,2,1,0 then IDLE.
    step("basic.load", 1'b1, 3, 1'b1);
    for (int i = 0; i < 5; i++) step("basic.run", 1'b0, 0, 1'b1);

    // Stall pattern on a load of 4.
    enp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    step("stall.load", 1'b1, 4, 1'b1);
    for (int i = 0; i < 6; i++) step("stall.run", 1'b0, 0, enp[i]);
    for (int i = 0; i < 2; i++) step("stall.tail", 1'b0, 0, 1'b1);

    // Zero load: done next cycle, busy never.
    step("zero.load", 1'b1, 0, 1'b1);
    step("zero.after", 1'b0, 0, 1'b1);
    // Back-to-back zero loads keep done high.
    step("zero.rep1", 1'b1, 0, 1'b0);
    step("zero.rep2", 1'b1, 0, 1'b0);
    step("zero.end", 1'b0, 0, 1'b0);

    // IDLE ignores en.
    for (int i = 0; i < 3; i++) step("idle.en", 1'b0, 0, 1'b1);

    // Restart mid-run: 10 -> 6, reload 2.
    step("restart.load", 1'b1, 10, 1'b1);
    for (int i = 0; i < 4; i++) step("restart.run", 1'b0, 0, 1'b1);
    check("restart.count6", int'(count), 6);
    step("restart.reload", 1'b1, 2, 1'b1);
    done_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step("restart.run2", 1'b0, 0, 1'b1);
      if (done) begin
        done_pulses++;
        check("restart.done_cycle", i, 1);  // 2nd edge after reload edge
      end
    end
    check("restart.done_pulses", done_pulses, 1);

    // Full width: 63 busy cycles, borrow across 32->31 and 16->15.
    step("full.load", 1'b1, MAXV, 1'b1);
    busy_cycles = 0;
    done_pulses = 0;
    for (int i = 0; i < MAXV + 2; i++) begin
      if (busy) busy_cycles++;
      step("full.run", 1'b0, 0, 1'b1);
      if (done) done_pulses++;
    end
    check("full.busy_cycles", busy_cycles, MAXV);
    check("full.done_pulses", done_pulses, 1);

    // Asynchronous reset in the middle of a run with count = 5.
    step("areset.load", 1'b1, 5, 1'b1);
    #3 clr_n = 1'b0;  // mid-cycle, no clock edge involved
    #1;
    model_reset();
    check_all("areset");
    #2 clr_n = 1'b1;
    step("areset.after", 1'b0, 0, 1'b1);

    // Randomized stimulus with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      bit s;
      int lv;
      bit e;
      s  = ($urandom_range(0, 11) == 0);
      lv = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1) : $urandom_range(0, MAXV);
      if ($urandom_range(0, 3) == 0) lv = $urandom_range(0, 20);
      e  = ($urandom_range(0, 3) != 0);
      step("rand", s, lv, e);
      if ($urandom_range(0, 499) == 0) begin
        #2 clr_n = 1'b0;
        #1;
        model_reset();
        check_all("rand.areset");
        #2 clr_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_countdown_sequencer
